// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - collapsing age-ordered reservation station with dual-CDB wakeup and oldest-ready select
// Optional same-cycle CDB-to-issue forwarding is enabled by defining RS_CDB_BYPASS_EN.
module reservation_station #(
    parameter  int DEPTH  = 8,
    parameter  int TAG_W  = 5,
    parameter  int DATA_W = 32,
    parameter  int OP_W   = 6,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              dispA_valid,
    input  logic [OP_W-1:0]   dispA_op,
    input  logic [DATA_W-1:0] dispA_src0,
    input  logic              dispA_src0_ready,
    input  logic [DATA_W-1:0] dispA_src1,
    input  logic              dispA_src1_ready,
    input  logic [TAG_W-1:0]  dispA_dest,

    input  logic              dispB_valid,
    input  logic [OP_W-1:0]   dispB_op,
    input  logic [DATA_W-1:0] dispB_src0,
    input  logic              dispB_src0_ready,
    input  logic [DATA_W-1:0] dispB_src1,
    input  logic              dispB_src1_ready,
    input  logic [TAG_W-1:0]  dispB_dest,

    output logic              disp_stall,

    input  logic              cdbA_valid,
    input  logic [TAG_W-1:0]  cdbA_tag,
    input  logic [DATA_W-1:0] cdbA_data,
    input  logic              cdbB_valid,
    input  logic [TAG_W-1:0]  cdbB_tag,
    input  logic [DATA_W-1:0] cdbB_data,

    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [OP_W-1:0]   issue_op,
    output logic [DATA_W-1:0] issue_src0,
    output logic [DATA_W-1:0] issue_src1,
    output logic [TAG_W-1:0]  issue_dest,

    output logic [CNT_W-1:0]  count
);

    typedef struct packed {
        logic              rdy;
        logic [DATA_W-1:0] val;
    } opnd_t;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dest;
        opnd_t             src0;
        opnd_t             src1;
    } entry_t;

    entry_t           ent_q   [DEPTH];
    entry_t           ent_d   [DEPTH];
    entry_t           woke    [DEPTH];
    entry_t           cand    [DEPTH];
    entry_t           shifted [DEPTH];
    entry_t           disp_a;
    entry_t           disp_b;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] base_idx;
    logic [CNT_W-1:0] idx_a;
    logic [CNT_W-1:0] idx_b;
    logic             acc_a;
    logic             acc_b;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             do_issue;

    // A waiting operand keeps its tag in the low bits of val; cdbA wins if both buses match.
    function automatic opnd_t snoop(input opnd_t o);
        opnd_t r;
        r = o;
        if (!o.rdy) begin
            if (cdbA_valid && (o.val[TAG_W-1:0] == cdbA_tag)) begin
                r.rdy = 1'b1;
                r.val = cdbA_data;
            end else if (cdbB_valid && (o.val[TAG_W-1:0] == cdbB_tag)) begin
                r.rdy = 1'b1;
                r.val = cdbB_data;
            end
        end
        return r;
    endfunction

    assign count      = rst_n ? count_q : '0;
    assign disp_stall = (count > CNT_W'(DEPTH - 2));

    always_comb begin : wake_select
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            woke[i]      = ent_q[i];
            woke[i].src0 = snoop(ent_q[i].src0);
            woke[i].src1 = snoop(ent_q[i].src1);
`ifdef RS_CDB_BYPASS_EN
            cand[i] = woke[i];
`else
            cand[i] = ent_q[i];
`endif
            if (!sel_found && cand[i].valid && cand[i].src0.rdy && cand[i].src1.rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin : issue_out
        issue_valid = rst_n && sel_found;
        issue_op    = '0;
        issue_src0  = '0;
        issue_src1  = '0;
        issue_dest  = '0;
        if (issue_valid) begin
            issue_op   = cand[sel_idx].op;
            issue_src0 = cand[sel_idx].src0.val;
            issue_src1 = cand[sel_idx].src1.val;
            issue_dest = cand[sel_idx].dest;
        end
    end

    assign do_issue = issue_valid && issue_ready;

    always_comb begin : dispatch_build
        disp_a       = '0;
        disp_a.valid = 1'b1;
        disp_a.op    = dispA_op;
        disp_a.dest  = dispA_dest;
        disp_a.src0  = snoop(opnd_t'({dispA_src0_ready, dispA_src0}));
        disp_a.src1  = snoop(opnd_t'({dispA_src1_ready, dispA_src1}));
        disp_b       = '0;
        disp_b.valid = 1'b1;
        disp_b.op    = dispB_op;
        disp_b.dest  = dispB_dest;
        disp_b.src0  = snoop(opnd_t'({dispB_src0_ready, dispB_src0}));
        disp_b.src1  = snoop(opnd_t'({dispB_src1_ready, dispB_src1}));
    end

    // Collapse above the issued slot first, then append new work at the post-shift tail.
    always_comb begin : next_state
        acc_a    = dispA_valid && !disp_stall;
        acc_b    = dispB_valid && !disp_stall;
        base_idx = count_q - CNT_W'(do_issue);
        idx_a    = base_idx;
        idx_b    = base_idx + CNT_W'(acc_a);
        for (int i = 0; i < DEPTH - 1; i++) begin
            shifted[i] = (do_issue && (i >= int'(sel_idx))) ? woke[i + 1] : woke[i];
        end
        shifted[DEPTH-1] = do_issue ? '0 : woke[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = shifted[i];
            if (acc_a && (CNT_W'(i) == idx_a)) ent_d[i] = disp_a;
            if (acc_b && (CNT_W'(i) == idx_b)) ent_d[i] = disp_b;
        end
        count_d = count_q + CNT_W'(acc_a) + CNT_W'(acc_b) - CNT_W'(do_issue);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i].valid <= 1'b0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - queue-model checked directed bench for reservation_station
module tb_reservation_station;

    localparam int DEPTH  = 8;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int OP_W   = 6;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dispA_valid, dispB_valid;
    logic [OP_W-1:0]   dispA_op, dispB_op;
    logic [DATA_W-1:0] dispA_src0, dispA_src1, dispB_src0, dispB_src1;
    logic              dispA_src0_ready, dispA_src1_ready, dispB_src0_ready, dispB_src1_ready;
    logic [TAG_W-1:0]  dispA_dest, dispB_dest;
    logic              disp_stall;
    logic              cdbA_valid, cdbB_valid;
    logic [TAG_W-1:0]  cdbA_tag, cdbB_tag;
    logic [DATA_W-1:0] cdbA_data, cdbB_data;
    logic              issue_valid, issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [DATA_W-1:0] issue_src0, issue_src1;
    logic [TAG_W-1:0]  issue_dest;
    logic [CNT_W-1:0]  count;

    always #5 clk = ~clk;

    reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .dispA_valid(dispA_valid), .dispA_op(dispA_op),
        .dispA_src0(dispA_src0), .dispA_src0_ready(dispA_src0_ready),
        .dispA_src1(dispA_src1), .dispA_src1_ready(dispA_src1_ready),
        .dispA_dest(dispA_dest),
        .dispB_valid(dispB_valid), .dispB_op(dispB_op),
        .dispB_src0(dispB_src0), .dispB_src0_ready(dispB_src0_ready),
        .dispB_src1(dispB_src1), .dispB_src1_ready(dispB_src1_ready),
        .dispB_dest(dispB_dest),
        .disp_stall(disp_stall),
        .cdbA_valid(cdbA_valid), .cdbA_tag(cdbA_tag), .cdbA_data(cdbA_data),
        .cdbB_valid(cdbB_valid), .cdbB_tag(cdbB_tag), .cdbB_data(cdbB_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_src0(issue_src0), .issue_src1(issue_src1),
        .issue_dest(issue_dest), .count(count)
    );

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dest;
        bit                r0;
        bit                r1;
        logic [DATA_W-1:0] v0;
        logic [DATA_W-1:0] v1;
    } m_t;

    m_t mq[$];
    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit cdb_hit(input bit r, input logic [DATA_W-1:0] v, output logic [DATA_W-1:0] d);
        logic [TAG_W-1:0] t;
        t = v[TAG_W-1:0];
        d = '0;
        if (r) return 1'b0;
        if (cdbA_valid && t == cdbA_tag) begin d = cdbA_data; return 1'b1; end
        if (cdbB_valid && t == cdbB_tag) begin d = cdbB_data; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic void model_select(output int sel, output logic [DATA_W-1:0] e0, output logic [DATA_W-1:0] e1);
        sel = -1;
        e0  = '0;
        e1  = '0;
        for (int i = 0; i < mq.size(); i++) begin
            bit r0, r1;
            logic [DATA_W-1:0] v0, v1;
`ifdef RS_CDB_BYPASS_EN
            logic [DATA_W-1:0] d;
`endif
            r0 = mq[i].r0; v0 = mq[i].v0;
            r1 = mq[i].r1; v1 = mq[i].v1;
`ifdef RS_CDB_BYPASS_EN
            if (cdb_hit(r0, v0, d)) begin r0 = 1'b1; v0 = d; end
            if (cdb_hit(r1, v1, d)) begin r1 = 1'b1; v1 = d; end
`endif
            if (sel < 0 && r0 && r1) begin sel = i; e0 = v0; e1 = v1; end
        end
    endfunction

    function automatic m_t mk(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] s0, input bit r0,
                              input logic [DATA_W-1:0] s1, input bit r1, input logic [TAG_W-1:0] dest);
        m_t e;
        logic [DATA_W-1:0] d;
        e.op = op; e.dest = dest; e.r0 = r0; e.v0 = s0; e.r1 = r1; e.v1 = s1;
        if (cdb_hit(e.r0, e.v0, d)) begin e.r0 = 1'b1; e.v0 = d; end
        if (cdb_hit(e.r1, e.v1, d)) begin e.r1 = 1'b1; e.v1 = d; end
        return e;
    endfunction

    always @(posedge clk) begin : model_update
        int sel;
        bit room;
        m_t e;
        logic [DATA_W-1:0] d, e0, e1;
        if (!rst_n) begin
            mq.delete();
        end else begin
            model_select(sel, e0, e1);
            room = (DEPTH - mq.size()) >= 2;
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (cdb_hit(e.r0, e.v0, d)) begin e.r0 = 1'b1; e.v0 = d; end
                if (cdb_hit(e.r1, e.v1, d)) begin e.r1 = 1'b1; e.v1 = d; end
                mq[i] = e;
            end
            if (sel >= 0 && issue_ready) mq.delete(sel);
            if (room && dispA_valid)
                mq.push_back(mk(dispA_op, dispA_src0, dispA_src0_ready, dispA_src1, dispA_src1_ready, dispA_dest));
            if (room && dispB_valid)
                mq.push_back(mk(dispB_op, dispB_src0, dispB_src0_ready, dispB_src1, dispB_src1_ready, dispB_dest));
        end
    end

    always @(negedge clk) begin : compare
        int sel;
        logic [DATA_W-1:0] e0, e1;
        #3;
        if (!rst_n) begin
            check("rst_count", 32'(count), 0);
            check("rst_issue_valid", 32'(issue_valid), 0);
            check("rst_disp_stall", 32'(disp_stall), 0);
        end else begin
            model_select(sel, e0, e1);
            check("count", 32'(count), mq.size());
            check("disp_stall", 32'(disp_stall), ((DEPTH - mq.size()) < 2) ? 1 : 0);
            check("issue_valid", 32'(issue_valid), (sel >= 0) ? 1 : 0);
            if (sel >= 0) begin
                check("issue_op", 32'(issue_op), 32'(mq[sel].op));
                check("issue_src0", issue_src0, e0);
                check("issue_src1", issue_src1, e1);
                check("issue_dest", 32'(issue_dest), 32'(mq[sel].dest));
            end
        end
    end

    task automatic idle();
        dispA_valid = 1'b0; dispB_valid = 1'b0;
        cdbA_valid  = 1'b0; cdbB_valid  = 1'b0;
    endtask

    task automatic drv_a(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] s0, input bit r0,
                         input logic [DATA_W-1:0] s1, input bit r1, input logic [TAG_W-1:0] dest);
        dispA_valid = 1'b1; dispA_op = op; dispA_dest = dest;
        dispA_src0 = s0; dispA_src0_ready = r0; dispA_src1 = s1; dispA_src1_ready = r1;
    endtask

    task automatic drv_b(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] s0, input bit r0,
                         input logic [DATA_W-1:0] s1, input bit r1, input logic [TAG_W-1:0] dest);
        dispB_valid = 1'b1; dispB_op = op; dispB_dest = dest;
        dispB_src0 = s0; dispB_src0_ready = r0; dispB_src1 = s1; dispB_src1_ready = r1;
    endtask

    task automatic cdb_a(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        cdbA_valid = 1'b1; cdbA_tag = t; cdbA_data = d;
    endtask

    task automatic cdb_b(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        cdbB_valid = 1'b1; cdbB_tag = t; cdbB_data = d;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; issue_ready = 1'b1;
        dispA_op = '0; dispA_src0 = '0; dispA_src1 = '0; dispA_src0_ready = 1'b0; dispA_src1_ready = 1'b0; dispA_dest = '0;
        dispB_op = '0; dispB_src0 = '0; dispB_src1 = '0; dispB_src0_ready = 1'b0; dispB_src1_ready = 1'b0; dispB_dest = '0;
        cdbA_tag = '0; cdbA_data = '0; cdbB_tag = '0; cdbB_data = '0;
        idle();
        tick();
        tick(); #4 check("lit_reset_count", 32'(count), 0); check("lit_reset_stall", 32'(disp_stall), 0);
        tick(); rst_n = 1'b1;

        // basic ready-ready dispatch, issue next cycle
        tick(); drv_a(6'd3, 32'd5, 1, 32'd7, 1, 5'd9);
        tick(); idle();
        #4 check("lit_t1_valid", 32'(issue_valid), 1); check("lit_t1_src0", issue_src0, 5);
        check("lit_t1_src1", issue_src1, 7); check("lit_t1_dest", 32'(issue_dest), 9);
        tick(); #4 check("lit_t1_count", 32'(count), 0);

        // wakeup through cdbB
        tick(); drv_a(6'd1, 32'd1, 1, 32'd12, 0, 5'd2);
        tick(); idle(); #4 check("lit_t2_wait", 32'(issue_valid), 0);
        tick(); cdb_b(5'd12, 32'hDEAD);
`ifdef RS_CDB_BYPASS_EN
        #4 check("lit_t2_byp_valid", 32'(issue_valid), 1); check("lit_t2_byp_src1", issue_src1, 32'hDEAD);
        tick(); idle(); #4 check("lit_t2_byp_count", 32'(count), 0);
`else
        #4 check("lit_t2_early", 32'(issue_valid), 0);
        tick(); idle(); #4 check("lit_t2_valid", 32'(issue_valid), 1); check("lit_t2_src1", issue_src1, 32'hDEAD);
`endif
        tick(); #4 check("lit_t2_count", 32'(count), 0);

        // dispatch-time capture, cdbA priority over cdbB
        tick(); drv_a(6'd5, 32'd4, 0, 32'h22, 1, 5'd6); cdb_a(5'd4, 32'h11); cdb_b(5'd4, 32'h99);
        tick(); idle();
        #4 check("lit_t5_valid", 32'(issue_valid), 1); check("lit_t5_src0", issue_src0, 32'h11);
        check("lit_t5_src1", issue_src1, 32'h22);
        tick();

        // issue_ready low holds the selected entry
        tick(); issue_ready = 1'b0; drv_a(6'd7, 32'd1, 1, 32'd2, 1, 5'd8);
        tick(); idle(); #4 check("lit_hold_dest", 32'(issue_dest), 8);
        tick(); #4 check("lit_hold_valid", 32'(issue_valid), 1); check("lit_hold_count", 32'(count), 1);
        tick(); issue_ready = 1'b1;
        tick(); #4 check("lit_hold_drain", 32'(count), 0);

        // dispatch + issue + wakeup in the same cycle
        tick(); drv_a(6'd10, 32'd10, 1, 32'd11, 1, 5'd10); drv_b(6'd11, 32'd3, 0, 32'd1, 1, 5'd11);
        tick(); idle(); drv_a(6'd12, 32'd12, 1, 32'd13, 1, 5'd12); cdb_a(5'd3, 32'h33);
        tick(); idle();
        repeat (3) tick();
        #4 check("lit_mix_drain", 32'(count), 0);

        // fill to DEPTH with waiting entries
        for (int j = 0; j < 4; j++) begin
            tick(); idle();
            drv_a(6'(2*j), 32'(20 + 2*j), 0, 32'(2*j), 1, 5'(20 + 2*j));
            drv_b(6'(2*j+1), 32'(21 + 2*j), 0, 32'(2*j+1), 1, 5'(21 + 2*j));
        end
        tick(); idle(); #4 check("lit_full_count", 32'(count), 8); check("lit_full_stall", 32'(disp_stall), 1);
        tick(); drv_a(6'd30, 32'd1, 1, 32'd1, 1, 5'd30); drv_b(6'd31, 32'd1, 1, 32'd1, 1, 5'd31);
        tick();
        tick(); idle(); #4 check("lit_full_ignored", 32'(count), 8);

        tick(); cdb_a(5'd20, 32'h100);
        tick(); idle();
        tick(); #4 check("lit_seven_count", 32'(count), 7); check("lit_seven_stall", 32'(disp_stall), 1);

        // entry 2 (tag 23) issues past older waiting entries
        tick(); cdb_a(5'd23, 32'h230);
        tick(); idle();
        tick(); #4 check("lit_mid_count", 32'(count), 6);

        tick(); cdb_a(5'd21, 32'h210); cdb_b(5'd22, 32'h220);
`ifdef RS_CDB_BYPASS_EN
        #4 check("lit_order_first", 32'(issue_dest), 21);
        tick(); idle(); #4 check("lit_order_second", 32'(issue_dest), 22);
`else
        tick(); idle(); #4 check("lit_order_first", 32'(issue_dest), 21);
        tick(); #4 check("lit_order_second", 32'(issue_dest), 22);
`endif
        tick(); #4 check("lit_order_count", 32'(count), 4);

        // reset with five queued entries
        tick(); drv_a(6'd40, 32'd28, 0, 32'd0, 1, 5'd28);
        tick(); idle(); #4 check("lit_pre_rst", 32'(count), 5);
        tick(); rst_n = 1'b0;
        #4 check("lit_in_rst_valid", 32'(issue_valid), 0);
        tick(); rst_n = 1'b1; cdb_a(5'd24, 32'h240); cdb_b(5'd25, 32'h250);
        #4 check("lit_post_rst_count", 32'(count), 0); check("lit_post_rst_valid", 32'(issue_valid), 0);
        tick(); idle();
        tick(); #4 check("lit_no_stale", 32'(issue_valid), 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Out-of-order holding buffer between the decode/register-file read stage and the integer execution unit. Accepts up to two decoded instructions per cycle (slots A and B) whose operands are either values or rename tags from the register file. Snoops two result broadcast buses to wake up waiting operands, and issues the oldest fully-ready entry to the execution unit each cycle.

## Interface
Parameters:
- DEPTH, 8: number of entries (≥ 2).
- TAG_W, 5: rename tag width.
- DATA_W, 32: operand width.
- OP_W, 6: opcode/control field width.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- dispA_valid / dispB_valid  in  1  dispatch request for slot A / B.
- dispA_op / dispB_op  in  OP_W  operation.
- dispA_src0, dispA_src1, dispB_src0, dispB_src1  in  DATA_W  operand value. When the matching ready bit is 0, the low TAG_W bits hold the tag.
- dispA_src0_ready … dispB_src1_ready  in  1  operand valid flags.
- dispA_dest / dispB_dest  in  TAG_W  destination rename tag.
- disp_stall  out  1  high when fewer than 2 entries are free.
- cdbA_valid / cdbB_valid  in  1  result broadcast valid.
- cdbA_tag / cdbB_tag  in  TAG_W  broadcast tag.
- cdbA_data / cdbB_data  in  DATA_W  broadcast value.
- issue_valid  out  1  an entry is ready to issue.
- issue_ready  in  1  the execution unit accepts this cycle.
- issue_op  out  OP_W  issued operation.
- issue_src0 / issue_src1  out  DATA_W  issued operands.
- issue_dest  out  TAG_W  issued destination tag.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
Storage:
- Collapsing age-ordered queue. Entry 0 is the oldest.
- Each entry holds valid, op, dest, and two {ready, value} operand fields.

Dispatch:
- Dispatch is ignored while disp_stall is high. Upstream must hold the request.
- A accepted with B: A is written at index count, B at count+1.
- B only: B is written at index count.
- A dispatched operand that is not ready but matches a valid CDB tag in the same cycle is stored ready with that CDB data. cdbA takes priority if both buses match.

Wakeup:
- Every valid, not-ready operand whose stored tag equals a valid cdbA_tag or cdbB_tag becomes ready with that bus's data at the next edge.

Select:
- The lowest-index valid entry with both operands ready drives the issue_* outputs. issue_valid=1 in that case.
- If no entry is ready, issue_valid=0 and the other issue_* outputs are don't-care (the implementation drives 0).

Removal:
- On issue_valid && issue_ready, the selected entry is removed. Younger entries shift down by one in the same edge, keeping age order.
- Dispatch writes land after the shift. Write index = count minus 1 if an issue occurs this cycle.

Count:
- count_next = count + accepted dispatches − issued. It never exceeds DEPTH and never goes below 0.

## Timing
- Reset (rst_n=0 at an edge) clears all valid bits and count.
- Outputs during and after reset: issue_valid=0, issue_* =0, count=0, disp_stall=0.
- Reset mid-operation discards all entries. No issue occurs in the reset cycle.
- Dispatch with both operands ready: earliest issue_valid is the next cycle.
- CDB wakeup: the operand is usable for select one cycle after the broadcast. See Configuration for the bypass case.
- disp_stall is combinational from registered count: disp_stall = (DEPTH − count) < 2. Issue in the current cycle does not release the stall.
- Issue handshake: while issue_ready=0 the selected entry stays. Outputs may change only if an older entry becomes ready.
- Full: count=DEPTH, dispatch ignored, issue still proceeds.
- Empty: issue_valid=0.
- Simultaneous issue + wakeup of the same entry: impossible, because the issued entry is already ready.
- Simultaneous dispatch + issue + wakeup all in one cycle is legal. All three take effect at the same edge.

## Configuration
- Macro RS_CDB_BYPASS_EN.
- Defined: select also treats an operand as ready if it matches a valid CDB tag this cycle. The CDB data is forwarded combinationally to issue_src*, giving wakeup-to-issue in the same cycle. The entry is removed normally if issue_ready.
- Undefined: select uses only stored ready bits, giving a one-cycle wakeup-to-issue latency.
- Dispatch-time CDB capture exists in both builds.

## Test plan
- Reset, then dispatch A with op=3, src0=5 (ready), src1=7 (ready), dest=9, and issue_ready=1 → next cycle issue_valid=1, issue_src0=5, issue_src1=7, issue_dest=9; the following cycle count=0.
- Dispatch A with src1 tag 12 not ready, then cdbB_valid with tag=12, data=0xDEAD → issue at broadcast+1 with issue_src1=0xDEAD. With RS_CDB_BYPASS_EN, issue occurs in the broadcast cycle.
- Fill to DEPTH=8 with non-ready entries → disp_stall=1 when count=7. Further dispatches are ignored and count stays at 8.
- Entries 0 and 1 not ready, entry 2 ready, issue_ready=1 → entry 2 issues. Remaining entries shift and age order is preserved; verify by waking entry 0 then entry 1 and checking issue order.
- Dispatch A with src0 tag 4 while cdbA_tag=4, data=0x11 in the same cycle → entry is stored ready and issues next cycle with src0=0x11.
- Assert rst_n=0 with 5 entries queued → next cycle count=0, issue_valid=0, and no stale entry issues afterward.
